// File: rtl/fpu_operand_prep.sv
// fpu_operand_prep: two-stage FP operand prep (single->double widen, NaN-box check, sign op, classify)
// Ports: clk/reset_n (async active-low), flush (sync drop of in-flight work),
//   in_valid/in_ready/in_ops/in_fmt/in_op/in_tag  : upstream transaction
//   out_valid/out_ready/out_ops/out_class/out_tag : prepared doubles, {snan,qnan,inf,zero,sub} per operand
module fpu_operand_prep #(
  parameter int NOPS = 3,
  parameter int TAGW = 6,
  parameter bit NANBOX_CHK = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NOPS*64-1:0]   in_ops,
  input  logic                 in_fmt,
  input  logic [2:0]           in_op,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NOPS*64-1:0]   out_ops,
  output logic [NOPS*5-1:0]    out_class,
  output logic [TAGW-1:0]      out_tag
);
  function automatic logic [4:0] clz23(input logic [22:0] f);
    logic [4:0] n;
    n = 5'd0;
    for (int k = 0; k < 23; k++) n = f[k] ? 5'(22 - k) : n;
    return n;
  endfunction

  // Single subnormals are renormalised: shift out the leading one, bias exponent down by lz.
  function automatic logic [63:0] widen(input logic [63:0] x, input logic fmt, input logic bad, input logic [4:0] lz);
    logic [7:0] e;
    logic [22:0] f, fs;
    logic [10:0] ew;
    e = x[30:23];
    f = x[22:0];
    fs = f << (lz + 5'd1);
    ew = e == 8'hFF ? 11'h7FF : e != 8'h0 ? {3'b0, e} + 11'd896 : f == 23'h0 ? 11'h0 : 11'd896 - {6'b0, lz};
    return !fmt ? x : bad ? 64'h7FF8_0000_0000_0000 : {x[31], ew, (e == 8'h0 && f != 23'h0) ? fs : f, 29'h0};
  endfunction

  function automatic logic [4:0] classify(input logic [63:0] v);
    logic eo, ez, fz;
    eo = &v[62:52];
    ez = ~|v[62:52];
    fz = ~|v[51:0];
    return {eo & ~fz & ~v[51], eo & v[51], eo & fz, ez & fz, ez & ~fz};
  endfunction

  logic                v1, v2, adv1, adv2;
  logic [NOPS*64-1:0]  ops1;
  logic                fmt1;
  logic [2:0]          op1;
  logic [TAGW-1:0]     tag1;
  logic [NOPS-1:0]     bad1, bad_n;
  logic [NOPS*5-1:0]   lz1, lz_n;
  logic [63:0]         cv [NOPS];
  logic [NOPS*64-1:0]  nxt_ops;
  logic [NOPS*5-1:0]   nxt_class;
  logic                sa, sb, ns;

  assign adv2 = ~v2 | out_ready;
  assign adv1 = ~v1 | adv2;
  assign in_ready = adv1;
  assign out_valid = v2;

  always_comb begin
    bad_n = '0;
    lz_n = '0;
    for (int i = 0; i < NOPS; i++) begin
      bad_n[i] = NANBOX_CHK && in_fmt && in_ops[64*i+32 +: 32] != 32'hFFFF_FFFF;
      lz_n[5*i +: 5] = clz23(in_ops[64*i +: 23]);
    end
  end

  always_comb begin
    for (int i = 0; i < NOPS; i++) cv[i] = widen(ops1[64*i +: 64], fmt1, bad1[i], lz1[5*i +: 5]);
    sa = cv[0][63];
    sb = cv[1][63];
    ns = op1 == 3'd1 ? ~sa : op1 == 3'd2 ? 1'b0 : op1 == 3'd3 ? sb : op1 == 3'd4 ? ~sb : op1 == 3'd5 ? sa ^ sb : sa;
    nxt_ops = '0;
    nxt_class = '0;
    for (int i = 0; i < NOPS; i++) begin
      nxt_ops[64*i +: 64] = i == 0 ? {ns, cv[0][62:0]} : cv[i];
      nxt_class[5*i +: 5] = classify(nxt_ops[64*i +: 64]);
    end
  end

  // Data regs load only with a valid transaction so idle outputs stay quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      ops1 <= '0;
      fmt1 <= 1'b0;
      op1 <= '0;
      tag1 <= '0;
      bad1 <= '0;
      lz1 <= '0;
      out_ops <= '0;
      out_class <= '0;
      out_tag <= '0;
    end else begin
      if (flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
      end else begin
        if (adv1) v1 <= in_valid;
        if (adv2) v2 <= v1;
      end
      if (adv1 && in_valid) begin
        ops1 <= in_ops;
        fmt1 <= in_fmt;
        op1 <= in_op;
        tag1 <= in_tag;
        bad1 <= bad_n;
        lz1 <= lz_n;
      end
      if (adv2 && v1) begin
        out_ops <= nxt_ops;
        out_class <= nxt_class;
        out_tag <= tag1;
      end
    end
  end
endmodule

// File: doc/fpu_operand_prep.md
# fpu_operand_prep

Pipelined FP operand-preparation stage between the register-file read and the FPU datapath. Accepts up to NOPS 64-bit operands per transaction and widens single-precision inputs to double precision, including NaN-box checking and subnormal normalisation. It applies sign-manipulation ops to operand 0 and emits a 5-bit class vector per operand. Transactions use a two-stage valid/ready pipeline with full backpressure, flush, and tag pass-through.

## Interface
- NOPS, 3, operand count (2 or 3; 3 for FMA)
- TAGW, 6, width of opaque tag carried alongside each transaction
- NANBOX_CHK, 1, 1 = non-NaN-boxed single inputs become canonical qNaN; 0 = upper 32 bits ignored
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops all in-flight transactions
- in_valid  in  1  input transaction valid
- in_ready  out  1  stage can accept this cycle
- in_ops  in  NOPS*64  operands, operand i at [64i+63:64i]
- in_fmt  in  1  0 = double, 1 = single (widen all operands)
- in_op  in  3  000 pass, 001 neg, 010 abs, 011 sgnj, 100 sgnjn, 101 sgnjx, 110/111 pass
- in_tag  in  TAGW  carried unchanged
- out_valid  out  1  output transaction valid
- out_ready  in  1  consumer accepts
- out_ops  out  NOPS*64  prepared double-precision operands
- out_class  out  NOPS*5  per operand {snan, qnan, inf, zero, subnormal}, operand i at [5i+4:5i]
- out_tag  out  TAGW  tag of the output transaction

## Operation
- in_fmt=0: operands pass unchanged before the sign op.
- in_fmt=1: use low 32 bits s,e8,f23. If NANBOX_CHK and bits[63:32]≠0xFFFFFFFF, the result is 0x7FF8000000000000.
- e8=0xFF: exp 0x7FF, fraction {f23, 29'b0}.
- 0<e8<0xFF: exp e8+896, fraction {f23, 29'b0}.
- e8=0, f23=0: signed zero.
- e8=0, f23≠0: lz = leading zeros of f23 (0..22). Exp = 896−lz. Fraction = (f23<<(lz+1)) truncated to 23 bits, then {.,29'b0}.
- Sign op on converted operand 0 (a) using converted operand 1 (b) sign:
  - neg: ~sa
  - abs: 0
  - sgnj: sb
  - sgnjn: ~sb
  - sgnjx: sa^sb
- Operands ≥1 are never sign-modified. The sign op applies to NaNs too, including a canonical NaN produced by the box check.
- Class is computed on the final output value:
  - snan: exp all ones, frac≠0, bit51=0
  - qnan: exp all ones, bit51=1
  - inf: exp all ones, frac=0
  - zero: exp=0, frac=0
  - subnormal: exp=0, frac≠0 (reachable only with in_fmt=0)
  - All bits are 0 for a normal value.
- Pipeline split:
  - S1 registers the inputs plus the box-check result and lz per operand.
  - S2 registers the converted, sign-adjusted operands and class. S2 drives the outputs.

## Timing
- Latency: 2 cycles from in_valid&in_ready to out_valid, with no stall.
- Throughput: 1 transaction per cycle.
- Advance equations (combinational ready chain, no bubble under continuous flow):
  - adv2 = ~v2 | out_ready
  - adv1 = ~v1 | adv2
  - in_ready = adv1
- S1 loads when adv1: v1 <= in_valid.
- S2 loads when adv2: v2 <= v1.
- Stalled stages hold data and valid stable. out_ops, out_class and out_tag must not change while out_valid&~out_ready.
- flush: v1 and v2 clear on the next edge. This overrides any simultaneous input accept. in_ready may be high during flush, but the accepted transaction is discarded.
- Reset (async assert, any cycle including mid-transfer):
  - v1 = v2 = 0, so out_valid = 0
  - out_ops = 0, out_class = 0, out_tag = 0
  - in_ready = 1 in the first cycle after deassertion
- No state other than the two stage registers; no counters survive flush or reset.

## Test plan
- Single widen: in_fmt=1, op0=0xFFFFFFFF3F800000, op=pass → out_ops[0]=0x3FF0000000000000, class 0, 2 cycles later.
- NaN-box fail: op0=0x000000003F800000, fmt=1, NANBOX_CHK=1 → 0x7FF8000000000000, class qnan. With op=neg → 0xFFF8000000000000.
- Subnormal and special values, fmt=1:
  - 0xFFFFFFFF00000001 → 0x36A0000000000000
  - 0xFFFFFFFF7F800000 → 0x7FF0000000000000, class inf
  - 0xFFFFFFFF7F800001 → 0x7FF0000020000000, class snan
- Sign ops, fmt=0, a=0x4000000000000000, b=0x8000000000000000:
  - sgnj → 0xC000000000000000
  - sgnjn → 0x4000000000000000
  - sgnjx → 0xC000000000000000
  - abs(0xC000000000000000) → 0x4000000000000000
- Backpressure: stream 5 transactions (tags 1..5) with out_ready low for 3 cycles mid-stream → in_ready drops once both stages are full. Outputs stay stable while stalled. Tags emerge 1..5 in order, with none lost or duplicated.
- Flush and reset:
  - flush with v1=v2=1 → out_valid=0 next cycle, and neither tag ever appears.
  - reset_n pulsed low mid-stream → out_valid=0 immediately (async), out_ops=0, in_ready=1 after release.
